// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul operand feeder.
// Holds FSM state encoding, MAX_DIM derivation and wavefront lengths.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int max_dim(
    input int bus_w,
    input int data_w
  );
    return bus_w / data_w;
  endfunction

  function automatic int feed_len(input int md);
    return 2 * md - 1;
  endfunction

  function automatic int drain_len(input int md);
    return md;
  endfunction

endpackage

// File: rtl/skew_lane_select.sv
// One wavefront lane: picks the skewed element of a snapshot or 0.
// With MATMUL_FEEDER_DIM_MASK_EN, elements beyond row_max/col_max read as 0.
module skew_lane_select
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int LANE       = 0,
  parameter bit TRANSPOSE  = 1'b0
) (
  input  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0] mat,
  input  logic [$clog2(2*MAX_DIM)-1:0]          step,
`ifdef MATMUL_FEEDER_DIM_MASK_EN
  input  logic [$clog2(MAX_DIM)-1:0]            row_max,
  input  logic [$clog2(MAX_DIM)-1:0]            col_max,
`endif
  output logic [DATA_WIDTH-1:0]                 elem
);

  int   off;
  int   row;
  int   col;
  logic hit;

  // A lanes walk along a row, B lanes walk down a column
  always_comb begin
    elem = '0;
    off  = int'(step) - LANE;
    row  = TRANSPOSE ? off : LANE;
    col  = TRANSPOSE ? LANE : off;
    hit  = (off >= 0) && (off < MAX_DIM);
`ifdef MATMUL_FEEDER_DIM_MASK_EN
    if (row > int'(row_max) || col > int'(col_max))
      hit = 1'b0;
`endif
    if (hit)
      elem = mat[(row*MAX_DIM+col)*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: rtl/matmul_skew_feeder.sv
// Snapshots A/B and streams skewed wavefronts plus drain zeros.
// Optional MATMUL_FEEDER_DIM_MASK_EN zeroes elements outside m/k/n dims.
module matmul_skew_feeder
  import matmul_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUS_WIDTH  = 32,
  localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int MW         = DATA_WIDTH*MAX_DIM*MAX_DIM,
  localparam int VW         = DATA_WIDTH*MAX_DIM
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [MW-1:0]              a_mat_i,
  input  logic [MW-1:0]              b_mat_i,
`ifdef MATMUL_FEEDER_DIM_MASK_EN
  input  logic [$clog2(MAX_DIM)-1:0] m_dim_i,
  input  logic [$clog2(MAX_DIM)-1:0] k_dim_i,
  input  logic [$clog2(MAX_DIM)-1:0] n_dim_i,
`endif
  output logic [VW-1:0]              a_flat_o,
  output logic [VW-1:0]              b_flat_o,
  output logic                       start_operation_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int SW = $clog2(2*MAX_DIM);
  localparam logic [SW-1:0] FEED_LAST  = SW'(feed_len(MAX_DIM) - 1);
  localparam logic [SW-1:0] DRAIN_LAST = SW'(drain_len(MAX_DIM) - 1);

  state_t        state;
  state_t        nxt_state;
  logic [SW-1:0] step;
  logic [SW-1:0] nxt_step;
  logic [MW-1:0] a_snap;
  logic [MW-1:0] b_snap;
  logic [MW-1:0] a_src;
  logic [MW-1:0] b_src;
  logic [VW-1:0] a_lanes;
  logic [VW-1:0] b_lanes;
  logic [VW-1:0] a_nxt;
  logic [VW-1:0] b_nxt;
  logic          run_nxt;
  logic          done_nxt;
  logic          take;

  // Outputs are registered, so lanes look at the snapshot being latched
  assign take  = (state == IDLE) && start_i;
  assign a_src = take ? a_mat_i : a_snap;
  assign b_src = take ? b_mat_i : b_snap;

`ifdef MATMUL_FEEDER_DIM_MASK_EN
  logic [$clog2(MAX_DIM)-1:0] m_snap, k_snap, n_snap;
  logic [$clog2(MAX_DIM)-1:0] m_src, k_src, n_src;

  assign m_src = take ? m_dim_i : m_snap;
  assign k_src = take ? k_dim_i : k_snap;
  assign n_src = take ? n_dim_i : n_snap;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_snap <= '0;
      k_snap <= '0;
      n_snap <= '0;
    end else begin
      m_snap <= m_src;
      k_snap <= k_src;
      n_snap <= n_src;
    end
  end
`endif

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
    skew_lane_select #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_DIM   (MAX_DIM),
      .LANE      (i),
      .TRANSPOSE (1'b0)
    ) u_a (
      .mat    (a_src),
      .step   (nxt_step),
`ifdef MATMUL_FEEDER_DIM_MASK_EN
      .row_max(m_src),
      .col_max(k_src),
`endif
      .elem   (a_lanes[i*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_lane_select #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_DIM   (MAX_DIM),
      .LANE      (i),
      .TRANSPOSE (1'b1)
    ) u_b (
      .mat    (b_src),
      .step   (nxt_step),
`ifdef MATMUL_FEEDER_DIM_MASK_EN
      .row_max(k_src),
      .col_max(n_src),
`endif
      .elem   (b_lanes[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      step   <= '0;
      a_snap <= '0;
      b_snap <= '0;
    end else begin
      state  <= nxt_state;
      step   <= nxt_step;
      a_snap <= a_src;
      b_snap <= b_src;
    end
  end

  always_comb begin
    nxt_state = state;
    unique case (1'b1)
      state == IDLE:  if (start_i) nxt_state = FEED;
      state == FEED:  if (step == FEED_LAST) nxt_state = DRAIN;
      state == DRAIN: if (step == DRAIN_LAST) nxt_state = DONE;
      default:        nxt_state = IDLE;
    endcase
    nxt_step = step + 1'b1;
    if (nxt_state != state || state == IDLE)
      nxt_step = '0;
  end

  always_comb begin
    a_nxt    = '0;
    b_nxt    = '0;
    run_nxt  = nxt_state != IDLE;
    done_nxt = nxt_state == DONE;
    if (nxt_state == FEED) begin
      a_nxt = a_lanes;
      b_nxt = b_lanes;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_flat_o          <= '0;
      b_flat_o          <= '0;
      start_operation_o <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      a_flat_o          <= a_nxt;
      b_flat_o          <= b_nxt;
      start_operation_o <= run_nxt;
      busy_o            <= run_nxt;
      done_o            <= done_nxt;
    end
  end

endmodule

// File: tb/tb_matmul_skew_feeder.sv
// Directed bench for matmul_skew_feeder at MAX_DIM=4.
// Define MATMUL_FEEDER_DIM_MASK_EN to also exercise dimension masking.
module tb_matmul_skew_feeder;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] a_mat = '0;
  logic [127:0] b_mat = '0;
  logic [31:0]  a_flat;
  logic [31:0]  b_flat;
  logic         start_op;
  logic         busy;
  logic         done;
`ifdef MATMUL_FEEDER_DIM_MASK_EN
  logic [1:0]   m_dim = 2'd3;
  logic [1:0]   k_dim = 2'd3;
  logic [1:0]   n_dim = 2'd3;
`endif

  int n_vec = 0;
  int n_err = 0;

  int vals [16] = '{1, 2, 3, 4, 5, 6, 7, 8,
                    8, 7, 6, 5, 4, 3, 2, 1};

  logic [31:0] exp_a [7] = '{
    32'h00000001, 32'h00000502, 32'h00080603, 32'h04070704,
    32'h03060800, 32'h02050000, 32'h01000000};
  logic [31:0] exp_b [7] = '{
    32'h00000001, 32'h00000205, 32'h00030608, 32'h04070704,
    32'h08060300, 32'h05020000, 32'h01000000};

  always #5 clk = ~clk;

  matmul_skew_feeder #(
    .DATA_WIDTH(8),
    .BUS_WIDTH (32)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .start_i          (start),
    .a_mat_i          (a_mat),
    .b_mat_i          (b_mat),
`ifdef MATMUL_FEEDER_DIM_MASK_EN
    .m_dim_i          (m_dim),
    .k_dim_i          (k_dim),
    .n_dim_i          (n_dim),
`endif
    .a_flat_o         (a_flat),
    .b_flat_o         (b_flat),
    .start_operation_o(start_op),
    .busy_o           (busy),
    .done_o           (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_mats;
    for (int i = 0; i < 16; i++) begin
      a_mat[i*8 +: 8] = 8'(vals[i]);
      b_mat[i*8 +: 8] = 8'(vals[i]);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if ({a_flat, b_flat, start_op, busy, done} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_outs got a=%h b=%h st=%b bz=%b dn=%b want all 0",
               a_flat, b_flat, start_op, busy, done);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({start_op, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got st/bz/dn=%b want 000",
               {start_op, busy, done});
    end
  endtask

  task automatic test_single_run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      n_vec++;
      if (a_flat !== exp_a[t]) begin
        n_err++;
        $display("FAIL %s a_step%0d got %h want %h", tag, t, a_flat, exp_a[t]);
      end
      n_vec++;
      if (b_flat !== exp_b[t]) begin
        n_err++;
        $display("FAIL %s b_step%0d got %h want %h", tag, t, b_flat, exp_b[t]);
      end
      n_vec++;
      if ({start_op, busy, done} !== 3'b110) begin
        n_err++;
        $display("FAIL %s feed_status%0d got %b want 110",
                 tag, t, {start_op, busy, done});
      end
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if ({a_flat, b_flat, start_op, busy, done} !== {64'd0, 3'b110}) begin
        n_err++;
        $display("FAIL %s drain%0d got a=%h b=%h stat=%b want 0/0/110",
                 tag, d, a_flat, b_flat, {start_op, busy, done});
      end
      tick();
    end
    n_vec++;
    if ({a_flat, b_flat, start_op, busy, done} !== {64'd0, 3'b111}) begin
      n_err++;
      $display("FAIL %s done_cycle got a=%h b=%h stat=%b want 0/0/111",
               tag, a_flat, b_flat, {start_op, busy, done});
    end
    tick();
    n_vec++;
    if ({start_op, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s back_idle got %b want 000",
               tag, {start_op, busy, done});
    end
  endtask

  task automatic test_back_to_back;
    start = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_busy%0d got %b want 1", c, busy);
      end
      if (c < 7) begin
        n_vec++;
        if ({a_flat, b_flat} !== {exp_a[c], exp_b[c]}) begin
          n_err++;
          $display("FAIL b2b_run1_step%0d got %h/%h want %h/%h",
                   c, a_flat, b_flat, exp_a[c], exp_b[c]);
        end
      end
      tick();
    end
    n_vec++;
    if ({start_op, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_gap got st/bz=%b want 00", {start_op, busy});
    end
    tick();
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      n_vec++;
      if ({busy, a_flat, b_flat} !== {1'b1, exp_a[t], exp_b[t]}) begin
        n_err++;
        $display("FAIL b2b_run2_step%0d got bz=%b %h/%h want 1 %h/%h",
                 t, busy, a_flat, b_flat, exp_a[t], exp_b[t]);
      end
      tick();
    end
    repeat (5) tick();
  endtask

  task automatic test_corrupt;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_mat = '1;
    b_mat = '1;
    for (int t = 0; t < 7; t++) begin
      n_vec++;
      if ({a_flat, b_flat} !== {exp_a[t], exp_b[t]}) begin
        n_err++;
        $display("FAIL corrupt_step%0d got %h/%h want %h/%h",
                 t, a_flat, b_flat, exp_a[t], exp_b[t]);
      end
      tick();
    end
    repeat (5) tick();
    load_mats();
  endtask

  task automatic test_reset_mid_run;
    bit saw = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (a_flat !== exp_a[3]) begin
      n_err++;
      $display("FAIL midrst_pre got %h want %h", a_flat, exp_a[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_flat, b_flat, start_op, busy, done} !== 67'd0) begin
      n_err++;
      $display("FAIL midrst_async got a=%h b=%h stat=%b want all 0",
               a_flat, b_flat, {start_op, busy, done});
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_quiet got activity=%b want 0", saw);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    test_single_run("after_rst");
  endtask

`ifdef MATMUL_FEEDER_DIM_MASK_EN
  task automatic test_mask;
    logic [31:0] ma [7] = '{32'h00000001, 32'h00000502, 32'h00000603,
                            32'h00000700, 32'h00000000, 32'h00000000,
                            32'h00000000};
    logic [31:0] mb [7] = '{32'h00000001, 32'h00000205, 32'h00030608,
                            32'h04070700, 32'h08060000, 32'h05000000,
                            32'h00000000};
    m_dim = 2'd1;
    k_dim = 2'd2;
    n_dim = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_dim = 2'd3;
    k_dim = 2'd3;
    for (int t = 0; t < 7; t++) begin
      n_vec++;
      if ({a_flat, b_flat} !== {ma[t], mb[t]}) begin
        n_err++;
        $display("FAIL mask_step%0d got %h/%h want %h/%h",
                 t, a_flat, b_flat, ma[t], mb[t]);
      end
      tick();
    end
    repeat (5) tick();
  endtask
`endif

  initial begin
    load_mats();
    test_reset();
    test_single_run("single");
    test_back_to_back();
    test_corrupt();
    test_reset_mid_run();
`ifdef MATMUL_FEEDER_DIM_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
